vga_mem_arbiter: RTL and testbench

// - Shares one single-port pixel memory between the VGA display fetch and N_WR drawing writers.
// - Sits between vga_timing (which supplies hcount/vcount/hblnk/vblnk) and the frame-buffer RAM.
// - Display fetch has absolute priority every cycle.
// - Writers are served round-robin in the cycles the display leaves free, in bursts of up to
//   MAX_BURST beats, optionally only during vertical blanking.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_rr_pick.sv | 32 +++
 rtl/vga_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types and constants: display timing, arbiter defaults, read-return tag.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 12;
  localparam int DEF_N_WR      = 2;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic {ARB, BURST} arb_state_t;

  // Tag that travels alongside a RAM access so its read data can be steered back.
  typedef struct packed {
    logic       is_disp;
    logic       is_wr;
    logic [1:0] owner;
  } rt_t;

  function automatic logic frame_origin(input logic [10:0] h, input logic [10:0] v);
    return (h == 11'd0) && (v == 11'd0);
  endfunction
endpackage

// File: rtl/vga_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_WR.
module vga_rr_pick #(
  parameter int N_WR = 2,
  parameter int PW   = 1
) (
  input  logic [N_WR-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_WR-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  localparam logic [PW:0] NV = (PW+1)'(N_WR);

  logic [PW:0] cand;

  // Scan N_WR candidates starting at ptr; one extra bit keeps the wrap exact for non-power-of-2 N_WR.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_WR; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= NV) cand = cand - NV;
      if (!any && req[cand[PW-1:0]]) begin
        any = 1'b1;
        idx = cand[PW-1:0];
      end
    end
    for (int j = 0; j < N_WR; j++) gnt[j] = any && (idx == PW'(j));
  end
endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame-buffer arbiter: display fetch first, writers round-robin in bursts.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_WR      = DEF_N_WR,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     vblnk,
  input  logic                     hblnk,
  input  logic [10:0]              vcount,
  input  logic [10:0]              hcount,
  input  logic                     vblank_only,
  input  logic                     disp_req,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic                     disp_rvalid,
  output logic [DATA_W-1:0]        disp_rdata,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR-1:0]          wr_we,
  input  logic [N_WR-1:0]          wr_last,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_wdata,
  output logic [N_WR-1:0]          wr_gnt,
  output logic [N_WR-1:0]          wr_rvalid,
  output logic [DATA_W-1:0]        wr_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     frame_start
);
  localparam int PW = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t  state, state_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n, owner, owner_n, sel;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic          win, beat;
  logic [N_WR-1:0] gnt, pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  rt_t             rt1;

  logic [N_WR-1:0][ADDR_W-1:0] wa;
  logic [N_WR-1:0][DATA_W-1:0] wd;
  assign wa = wr_addr;
  assign wd = wr_wdata;

  // hblnk is part of the vga_timing bundle but plays no role in arbitration.
  logic unused_in;
  assign unused_in = hblnk;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(1);
    if (s >= (PW+1)'(N_WR)) s = '0;
    return s[PW-1:0];
  endfunction

  assign win = !disp_req && (vblank_only ? vblnk : 1'b1);

  vga_rr_pick #(.N_WR(N_WR), .PW(PW)) u_pick (
    .req (wr_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next state, grant and beat selection; grants are forced off while reset is asserted.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    gnt        = '0;
    beat       = 1'b0;
    sel        = owner;
    case (state)
      ARB: begin
        if (win && pick_any) begin
          gnt        = pick_gnt;
          beat       = 1'b1;
          sel        = pick_idx;
          owner_n    = pick_idx;
          beat_cnt_n = BW'(1);
          if (wr_last[pick_idx] || (MAX_BURST == 1)) rr_ptr_n = ptr_inc(pick_idx);
          else                                       state_n  = BURST;
        end
      end
      BURST: begin
        if (!wr_req[owner]) begin
          state_n  = ARB;
          rr_ptr_n = ptr_inc(owner);
        end else if (win) begin
          gnt[owner] = 1'b1;
          beat       = 1'b1;
          beat_cnt_n = beat_cnt + BW'(1);
          if (wr_last[owner] || (beat_cnt + BW'(1) == BW'(MAX_BURST))) begin
            state_n  = ARB;
            rr_ptr_n = ptr_inc(owner);
          end
        end
      end
      default: state_n = ARB;
    endcase
    if (!rst) begin
      gnt  = '0;
      beat = 1'b0;
    end
  end

  assign wr_gnt = gnt;

  // Arbiter state register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // RAM command register: display overrides, otherwise the granted beat, otherwise idle.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (disp_req) begin
      mem_addr <= disp_addr;
      mem_we   <= 1'b0;
    end else if (beat) begin
      mem_addr  <= wa[sel];
      mem_we    <= wr_we[sel];
      mem_wdata <= wd[sel];
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Return-path tag: stage 1 tracks the RAM command, stage 2 lines up with mem_rdata.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rt1         <= '0;
      disp_rvalid <= 1'b0;
      wr_rvalid   <= '0;
    end else begin
      rt1 <= '{is_disp: disp_req, is_wr: beat && !wr_we[sel], owner: 2'(sel)};
      disp_rvalid <= rt1.is_disp;
      for (int j = 0; j < N_WR; j++) wr_rvalid[j] <= rt1.is_wr && (rt1.owner == 2'(j));
    end
  end

  assign disp_rdata = disp_rvalid ? mem_rdata : '0;
  assign wr_rdata   = (|wr_rvalid) ? mem_rdata : '0;

  // Frame origin pulse, one cycle behind the counters.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) frame_start <= 1'b0;
    else      frame_start <= frame_origin(hcount, vcount);
  end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter with a 1-cycle-latency RAM model.
module tb_vga_mem_arbiter;
  import vga_pkg::*;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  logic vblnk, hblnk, vblank_only, disp_req;
  logic [10:0] vcount, hcount;
  logic [15:0] disp_addr;
  logic        disp_rvalid;
  logic [11:0] disp_rdata;
  logic [1:0]  wr_req, wr_we, wr_last, wr_gnt, wr_rvalid;
  logic [31:0] wr_addr;
  logic [23:0] wr_wdata;
  logic [11:0] wr_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_we, frame_start;

  always #5 pclk = ~pclk;

  vga_mem_arbiter dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .hblnk(hblnk), .vcount(vcount), .hcount(hcount),
    .vblank_only(vblank_only), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .wr_req(wr_req), .wr_we(wr_we),
    .wr_last(wr_last), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_gnt(wr_gnt),
    .wr_rvalid(wr_rvalid), .wr_rdata(wr_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .frame_start(frame_start)
  );

  function automatic logic [11:0] pat(input logic [15:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  // RAM: unwritten locations read back as pat(addr).
  logic [11:0] wmem [int];
  always @(posedge pclk) begin
    mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : pat(mem_addr);
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
  end

  typedef struct { logic [15:0] a; logic [11:0] d; } wexp_t;
  typedef struct { int w; logic [11:0] d; } rexp_t;
  wexp_t       exp_wr[$];
  logic [11:0] exp_disp[$];
  rexp_t       exp_rd[$];
  logic [1:0]  gq[$];
  int          fq[$];

  int checks = 0, failures = 0, cyc_no = 0, gnt_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Writer stimulus state.
  int          w_left[2], w_n[2];
  logic        w_we[2], w_laste[2], w_lastf[2];
  logic [15:0] w_abase[2];
  logic [11:0] w_dbase[2];
  logic [1:0]  fire;

  task automatic setw(input int i, input int left, input logic [15:0] ab, input logic [11:0] db,
                      input logic we, input logic laste, input logic lastf);
    w_left[i] = left; w_n[i] = 0; w_abase[i] = ab; w_dbase[i] = db;
    w_we[i] = we; w_laste[i] = laste; w_lastf[i] = lastf;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      wr_req[i]  = w_left[i] > 0;
      wr_we[i]   = w_we[i];
      wr_last[i] = w_laste[i] || (w_lastf[i] && w_left[i] == 1);
      wr_addr[i*16 +: 16]  = w_abase[i] + 16'(w_n[i]);
      wr_wdata[i*12 +: 12] = w_dbase[i] + 12'(w_n[i]);
    end
  endtask

  task automatic push_w(input logic [15:0] a, input logic [11:0] d);
    wexp_t e; e.a = a; e.d = d; exp_wr.push_back(e);
  endtask

  task automatic push_r(input int w, input logic [11:0] d);
    rexp_t r; r.w = w; r.d = d; exp_rd.push_back(r);
  endtask

  // One clock: sample beats at the falling edge, advance writers just after the rising edge.
  task automatic cyc();
    @(negedge pclk);
    fire = wr_req & wr_gnt;
    if (wr_gnt != 2'b00) gnt_cycles++;
    if (fire != 2'b00) begin gq.push_back(wr_gnt); fq.push_back(cyc_no); end
    if (rst && disp_req) exp_disp.push_back(pat(disp_addr));
    cyc_no++;
    @(posedge pclk); #1;
    for (int i = 0; i < 2; i++) if (fire[i]) begin w_n[i]++; w_left[i]--; end
    drive();
  endtask

  // Monitor: every RAM write and read return is matched against the scoreboard.
  wexp_t me;
  rexp_t mr;
  always @(negedge pclk) begin
    if (rst) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          me = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(me.a));
          chk("wr_data", 32'(mem_wdata), 32'(me.d));
        end
      end
      if (disp_rvalid) begin
        if (exp_disp.size() == 0) chk("disp_unexpected", 1, 0);
        else chk("disp_rdata", 32'(disp_rdata), 32'(exp_disp.pop_front()));
      end
      if (wr_rvalid != 2'b00) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          mr = exp_rd.pop_front();
          chk("rd_writer", 32'(wr_rvalid), 32'(1) << mr.w);
          chk("rd_data", 32'(wr_rdata), 32'(mr.d));
        end
      end
    end
  end

  function automatic logic any_out();
    return |{mem_addr, mem_we, mem_wdata, disp_rvalid, disp_rdata, wr_gnt, wr_rvalid,
             wr_rdata, frame_start};
  endfunction

  logic [1:0] eg;
  int c0;

  initial begin
    vblnk = 0; hblnk = 0; vblank_only = 0; disp_req = 0; disp_addr = '0;
    vcount = 11'd5; hcount = 11'd5;
    setw(0, 0, 16'h0, 12'h0, 1, 0, 0);
    setw(1, 0, 16'h0, 12'h0, 1, 0, 0);
    drive();
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_outputs", 32'(any_out()), 0);
    rst = 1;
    repeat (2) cyc();

    // Reset mid-burst: two writes land, the third is killed by reset.
    setw(0, 6, 16'h1300, 12'h600, 1, 0, 1);
    push_w(16'h1300, 12'h600); push_w(16'h1301, 12'h601);
    drive();
    repeat (3) cyc();
    chk("rst_beats", gq.size(), 3);
    rst = 0; #1;
    chk("rst_mid_outputs", 32'(any_out()), 0);
    w_left[0] = 0; drive();
    repeat (2) cyc();
    rst = 1; #1;
    chk("rst_state", 32'(dut.state), 32'(ARB));
    chk("rst_ptr", 32'(dut.rr_ptr), 0);
    cyc();
    gq.delete(); fq.delete();

    // Display priority: 800 cycles of display fetch starve both writers.
    setw(0, 1, 16'h1000, 12'h100, 1, 1, 0);
    setw(1, 1, 16'h2000, 12'h200, 1, 1, 0);
    push_w(16'h1000, 12'h100); push_w(16'h2000, 12'h200);
    disp_req = 1; gnt_cycles = 0;
    for (int k = 0; k < 800; k++) begin
      disp_addr = 16'h3000 + 16'(k);
      cyc();
    end
    chk("disp_prio_gnt", gnt_cycles, 0);
    disp_req = 0; drive();
    repeat (6) cyc();
    chk("disp_reads_left", exp_disp.size(), 0);
    chk("after_disp_n", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("after_disp_g0", 32'(gq[0]), 32'h1);
      chk("after_disp_g1", 32'(gq[1]), 32'h2);
    end
    gq.delete(); fq.delete();

    // Round robin on single-beat transfers.
    setw(0, 2, 16'h1010, 12'h110, 1, 1, 0);
    setw(1, 2, 16'h2010, 12'h210, 1, 1, 0);
    push_w(16'h1010, 12'h110); push_w(16'h2010, 12'h210);
    push_w(16'h1011, 12'h111); push_w(16'h2011, 12'h211);
    drive();
    repeat (8) cyc();
    chk("rr_n", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", 32'(gq[k]), 32'(eg));
    end
    gq.delete(); fq.delete();

    // Burst limit: 8 beats of writer0, writer1's 3-beat burst, then writer0's remaining 12.
    setw(0, 20, 16'h1100, 12'h300, 1, 0, 0);
    setw(1, 3, 16'h2100, 12'h400, 1, 0, 1);
    for (int k = 0; k < 8; k++)  push_w(16'h1100 + 16'(k), 12'h300 + 12'(k));
    for (int k = 0; k < 3; k++)  push_w(16'h2100 + 16'(k), 12'h400 + 12'(k));
    for (int k = 8; k < 20; k++) push_w(16'h1100 + 16'(k), 12'h300 + 12'(k));
    drive();
    repeat (30) cyc();
    chk("burst_n", gq.size(), 23);
    for (int k = 0; k < 23 && k < gq.size(); k++) begin
      eg = (k >= 8 && k < 11) ? 2'b10 : 2'b01;
      chk("burst_gnt", 32'(gq[k]), 32'(eg));
    end
    gq.delete(); fq.delete();

    // Preemption: display takes 3 cycles where beat 4 would go.
    setw(0, 6, 16'h1200, 12'h500, 1, 0, 1);
    for (int k = 0; k < 6; k++) push_w(16'h1200 + 16'(k), 12'h500 + 12'(k));
    drive();
    c0 = cyc_no;
    for (int c = 0; c < 12; c++) begin
      disp_req  = (c >= 3 && c < 6);
      disp_addr = 16'h3400 + 16'(c);
      cyc();
    end
    disp_req = 0;
    chk("preempt_n", fq.size(), 6);
    if (fq.size() == 6) begin
      chk("preempt_b1", fq[0] - c0, 0);
      chk("preempt_b3", fq[2] - c0, 2);
      chk("preempt_b4", fq[3] - c0, 6);
      chk("preempt_b6", fq[5] - c0, 8);
    end
    gq.delete(); fq.delete();

    // vblank-only window with reads routed back to the right writer.
    vblank_only = 1; vblnk = 0;
    setw(0, 2, 16'h0040, 12'h0, 0, 1, 0);
    setw(1, 1, 16'h1000, 12'h0, 0, 1, 0);
    push_r(1, 12'h100); push_r(0, pat(16'h0040)); push_r(0, pat(16'h0041));
    drive();
    repeat (10) cyc();
    chk("vbl_blocked", gq.size(), 0);
    vblnk = 1;
    c0 = cyc_no;
    repeat (6) cyc();
    chk("vbl_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("vbl_first", fq[0] - c0, 0);
      chk("vbl_g0", 32'(gq[0]), 32'h2);
      chk("vbl_g1", 32'(gq[1]), 32'h1);
      chk("vbl_g2", 32'(gq[2]), 32'h1);
    end
    vblank_only = 0; vblnk = 0;
    gq.delete(); fq.delete();

    // frame_start: one-cycle pulse, one cycle after the origin.
    hcount = 11'd0; vcount = 11'd0;
    @(negedge pclk); chk("fs_pre", 32'(frame_start), 0);
    @(posedge pclk); #1; hcount = 11'd1;
    @(negedge pclk); chk("fs_pulse", 32'(frame_start), 1);
    @(posedge pclk); #1;
    @(negedge pclk); chk("fs_clear", 32'(frame_start), 0);
    @(posedge pclk); #1;

    repeat (4) cyc();
    chk("wr_left", exp_wr.size(), 0);
    chk("disp_left", exp_disp.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
